// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit driving a byte-banked data-memory port.
//
// Takes one core load/store request at a time on a valid/ready handshake.
// Each request is checked for address range and funct3 legality, then
// forwarded to the memory port. Store and error responses are returned one
// cycle after accept. Load responses are returned two cycles after accept,
// once the memory's registered read data has been sign/zero-extended.
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_req_*            core request (valid/ready, we, funct3, addr, wdata)
//   o_rsp_*            core response (valid/ready, rdata, err)
//   o_mem_*            memory port drive (addr, we, size, din)
//   i_mem_dout         memory read data, one cycle after the address
module dmem_lsu #(
  parameter int unsigned DMEM_DEPTH      = 1024,
  parameter int unsigned DMEM_ADDR_WIDTH = 12,
  parameter logic [31:0] DMEM_BASE       = 32'h0000_0000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_req_we,
  input  logic [2:0]                 i_req_funct3,
  input  logic [31:0]                i_req_addr,
  input  logic [31:0]                i_req_wdata,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [31:0]                o_rsp_rdata,
  output logic                       o_rsp_err,
  output logic [DMEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic                       o_mem_we,
  output logic [1:0]                 o_mem_size,
  output logic [31:0]                o_mem_din,
  input  logic [31:0]                i_mem_dout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RESP      = 2'd2
  } state_e;

  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_DEPTH * 4);

  state_e      state_q, state_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [2:0]  load_f3_q, load_f3_d;

  logic        accept;
  logic [31:0] addr_off;
  logic        range_err;
  logic        f3_err;
  logic        req_err;
  logic [31:0] load_ext;

  // Request side. Ready is withheld during reset so that a request presented
  // while reset is asserted never looks accepted.
  always_comb begin
    o_req_ready = !i_rst && ((state_q == IDLE) || ((state_q == RESP) && i_rsp_ready));
    accept      = i_req_valid && o_req_ready;

    // Unsigned wrap makes addresses below the base land far out of range.
    addr_off    = i_req_addr - DMEM_BASE;
    range_err   = (addr_off >= DMEM_BYTES);
    f3_err      = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11) ||
                  (i_req_we && i_req_funct3[2]);
    req_err     = range_err || f3_err;

    o_mem_addr  = i_req_addr[DMEM_ADDR_WIDTH-1:0];
    o_mem_din   = i_req_wdata;
    o_mem_size  = (i_req_funct3[1:0] == 2'b11) ? 2'b10 : i_req_funct3[1:0];
    o_mem_we    = accept && i_req_we && !req_err;
  end

  // Extension of the memory's read data, using the funct3 captured at accept.
  always_comb begin
    case (load_f3_q)
      3'b000:  load_ext = {{24{i_mem_dout[7]}}, i_mem_dout[7:0]};
      3'b100:  load_ext = {24'h0, i_mem_dout[7:0]};
      3'b001:  load_ext = {{16{i_mem_dout[15]}}, i_mem_dout[15:0]};
      3'b101:  load_ext = {16'h0, i_mem_dout[15:0]};
      default: load_ext = i_mem_dout;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    load_f3_d   = load_f3_q;

    case (state_q)
      LOAD_WAIT: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_ext;
        rsp_err_d   = 1'b0;
      end
      RESP: begin
        // Without a handshake the response registers simply hold.
        if (i_rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: ;
    endcase

    // A new accept (from IDLE, or from RESP as the old response retires)
    // takes precedence over the retire-to-IDLE transition above.
    if (accept) begin
      rsp_rdata_d = 32'h0;
      if (req_err) begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end else if (i_req_we) begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
      end else begin
        state_d     = LOAD_WAIT;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        load_f3_d   = i_req_funct3;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      load_f3_q   <= 3'b000;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      load_f3_q   <= load_f3_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench for dmem_lsu.
// Requests are issued by a driver that pushes the expected response (computed
// from a byte-array reference of memory contents) into a queue at accept. A
// separate monitor pops and compares whenever a response is presented.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [11:0] o_mem_addr;
  logic        o_mem_we;
  logic [1:0]  o_mem_size;
  logic [31:0] o_mem_din;
  logic [31:0] i_mem_dout;

  dmem_lsu dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err),
    .o_mem_addr   (o_mem_addr),
    .o_mem_we     (o_mem_we),
    .o_mem_size   (o_mem_size),
    .o_mem_din    (o_mem_din),
    .i_mem_dout   (i_mem_dout)
  );

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          BYTES = 4096;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-banked memory behind the port: registered read, byte writes.
  logic [7:0] mem_bytes [0:BYTES-1];
  logic [7:0] ref_bytes [0:BYTES-1];
  int         ma;
  int         mn;

  always @(posedge clk) begin
    ma = int'(o_mem_addr);
    i_mem_dout <= {mem_bytes[(ma+3)%BYTES], mem_bytes[(ma+2)%BYTES],
                   mem_bytes[(ma+1)%BYTES], mem_bytes[ma%BYTES]};
    if (o_mem_we) begin
      mn = (o_mem_size == 2'd0) ? 1 : (o_mem_size == 2'd1) ? 2 : 4;
      for (int k = 0; k < mn; k++) mem_bytes[(ma+k)%BYTES] = o_mem_din[8*k +: 8];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  logic pending = 1'b0;
  logic mon_en  = 1'b0;
  logic force_mode = 1'b1;
  logic forced_val = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: decide error, update reference bytes, compute load value.
  task automatic model_accept(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] off;
    logic        err;
    int          idx;
    int          nb;
    logic [31:0] w;
    logic [31:0] v;
    exp_t        e;
    off = addr - BASE;
    err = (off >= 32'(BYTES)) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
          (we && f3[2]);
    idx = int'(off[11:0]);
    check("acc_we", {31'h0, o_mem_we}, {31'h0, (we && !err)});
    check("acc_size", {30'h0, o_mem_size}, {30'h0, (f3[1:0] == 2'd3) ? 2'd2 : f3[1:0]});
    check("acc_addr", {20'h0, o_mem_addr}, {20'h0, addr[11:0]});
    e.rdata = 32'h0;
    e.err   = err;
    e.cyc   = cyc + 1;
    if (!err && we) begin
      nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      for (int k = 0; k < nb; k++) ref_bytes[(idx+k)%BYTES] = wd[8*k +: 8];
    end else if (!err) begin
      w = {ref_bytes[(idx+3)%BYTES], ref_bytes[(idx+2)%BYTES],
           ref_bytes[(idx+1)%BYTES], ref_bytes[idx%BYTES]};
      case (f3)
        3'd0:    v = 32'(signed'(w[7:0]));
        3'd4:    v = 32'(w[7:0]);
        3'd1:    v = 32'(signed'(w[15:0]));
        3'd5:    v = 32'(w[15:0]);
        default: v = w;
      endcase
      e.rdata = v;
      e.cyc   = cyc + 2;
    end
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the rising edge
  // that completes the accept.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int waits);
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = addr;
    i_req_wdata  = wd;
    waits = 0;
    forever begin
      @(negedge clk);
      if (o_req_ready) begin
        model_accept(we, f3, addr, wd);
        break;
      end
      waits++;
      if (waits > 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL req_timeout: got no ready expected ready within 100 cycles");
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
  endtask

  task automatic drain();
    force_mode = 1'b1;
    forced_val = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Response-ready driver.
  initial begin
    i_rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      i_rsp_ready = force_mode ? forced_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares every presented response against the queue head.
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (i_rst || !(i_req_valid && o_req_ready))
        check("idle_we", {31'h0, o_mem_we}, 32'h0);
      if (o_rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got rdata %h err %0d expected no response",
                   o_rsp_rdata, o_rsp_err);
        end else begin
          if (!pending) check("rsp_latency", 32'(cyc), 32'(exp_q[0].cyc));
          check("rsp_rdata", o_rsp_rdata, exp_q[0].rdata);
          check("rsp_err", {31'h0, o_rsp_err}, {31'h0, exp_q[0].err});
          if (i_rsp_ready) begin
            void'(exp_q.pop_front());
            pending = 1'b0;
          end else begin
            pending = 1'b1;
          end
        end
      end else if (pending) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_dropped: got valid 0 expected held response");
        pending = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  int          w;
  logic [31:0] rwd;
  logic [31:0] raddr;
  logic [2:0]  rf3;
  logic        rwe;

  initial begin
    for (int i = 0; i < BYTES; i++) begin
      mem_bytes[i] = 8'($urandom);
      ref_bytes[i] = mem_bytes[i];
    end
    i_rst        = 1'b1;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_funct3 = 3'd0;
    i_req_addr   = 32'h0;
    i_req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
    check("rst_rsp_rdata", o_rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'h0, o_rsp_err}, 32'h0);
    check("rst_mem_we", {31'h0, o_mem_we}, 32'h0);
    check("rst_req_ready", {31'h0, o_req_ready}, 32'h1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    force_mode = 1'b0;

    // Directed cases.
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, w);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, w);
    do_req(1'b1, 3'd0, 32'h21, 32'h80, w);
    do_req(1'b0, 3'd0, 32'h21, 32'h0, w);
    do_req(1'b0, 3'd4, 32'h21, 32'h0, w);
    do_req(1'b1, 3'd1, 32'h23, 32'h8001, w);
    do_req(1'b0, 3'd1, 32'h23, 32'h0, w);
    do_req(1'b0, 3'd5, 32'h23, 32'h0, w);
    do_req(1'b0, 3'd2, BASE + 32'd4096, 32'h0, w);
    do_req(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h1234_5678, w);
    do_req(1'b0, 3'd3, 32'h40, 32'h0, w);
    do_req(1'b1, 3'd4, 32'h40, 32'hCAFE_F00D, w);
    do_req(1'b0, 3'd2, 32'h40, 32'h0, w);
    do_req(1'b0, 3'd2, 32'hFFC, 32'h0, w);

    // Back-pressure: LW response stalled, queued SW waits then goes through.
    drain();
    forced_val = 1'b0;
    do_req(1'b0, 3'd2, 32'h10, 32'h0, w);
    rwd = $urandom;
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_funct3 = 3'd2;
    i_req_addr   = 32'h14;
    i_req_wdata  = rwd;
    for (int n = 0; n < 10 && !o_rsp_valid; n++) @(negedge clk);
    check("stall_rsp_seen", {31'h0, o_rsp_valid}, 32'h1);
    repeat (5) begin
      @(negedge clk);
      check("stall_req_ready", {31'h0, o_req_ready}, 32'h0);
    end
    @(posedge clk);
    #1;
    forced_val = 1'b1;
    do_req(1'b1, 3'd2, 32'h14, rwd, w);
    check("stall_same_cycle_accept", 32'(w), 32'd0);
    do_req(1'b0, 3'd2, 32'h14, 32'h0, w);

    // Reset while a load is in flight, with a store presented during reset.
    drain();
    do_req(1'b0, 3'd2, 32'h10, 32'h0, w);
    i_rst        = 1'b1;
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_funct3 = 3'd2;
    i_req_addr   = 32'h80;
    i_req_wdata  = 32'h1234_5678;
    exp_q.delete();
    pending = 1'b0;
    @(negedge clk);
    check("rst_mid_we", {31'h0, o_mem_we}, 32'h0);
    @(posedge clk);
    #1;
    i_rst       = 1'b0;
    i_req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
    check("rst_mid_req_ready", {31'h0, o_req_ready}, 32'h1);
    check("rst_mid_mem_we", {31'h0, o_mem_we}, 32'h0);
    @(posedge clk);
    #1;
    do_req(1'b0, 3'd2, 32'h80, 32'h0, w);

    // Randomized traffic with random response back-pressure.
    force_mode = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rwe = 1'($urandom);
      rf3 = 3'($urandom);
      if ($urandom_range(0, 9) != 0) rf3 = {1'b0, 2'($urandom_range(0, 2))};
      if ($urandom_range(0, 9) == 0) rf3 = 3'($urandom_range(4, 5));
      raddr = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 4095));
      rwd = $urandom;
      do_req(rwe, rf3, raddr, rwd, w);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    drain();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
